// File: rtl/commit_stage_pkg.sv
// Shared types for the retirement path: ROB head entry layout, datapath widths
// and the commit-stage state encoding.
package commit_stage_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = REG_W'(0);

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef struct packed {
        logic             valid;
        logic             wr_mem;
        logic [REG_W-1:0] dest_reg;
        logic [XLEN-1:0]  value;
        logic [XLEN-1:0]  dest_addr;
    } ROB_ENTRY;

    typedef enum logic {
        IDLE      = 1'b0,
        STORE_REQ = 1'b1
    } COMMIT_STATE;

endpackage

// File: rtl/commit_stage.sv
// In-order retirement of the ROB head: ALU results go straight to the register
// file; stores wait on a memory handshake before the head is dequeued.
module commit_stage
    import commit_stage_pkg::*;
#(
    parameter int unsigned MAX_STORE_WAIT = 15,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  ROB_ENTRY             head_entry,
    input  logic                 head_ready,
    input  logic                 halt,
    input  logic                 mem_req_ready,
    output logic                 commit,
    output logic                 rf_wr_en,
    output logic [REG_W-1:0]     rf_wr_idx,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic                 mem_req_valid,
    output logic [XLEN-1:0]      mem_req_addr,
    output logic [XLEN-1:0]      mem_req_data,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 store_timeout
);

    localparam int unsigned WAIT_W = $clog2(MAX_STORE_WAIT + 1);

    COMMIT_STATE       state;
    logic              retire_alu;
    logic              start_store;
    logic              store_accept;
    logic              wait_inc;
    logic [WAIT_W-1:0] wait_cnt;

    // Decode this cycle's action; the stage is inert while reset is held.
    always_comb begin
        retire_alu   = FALSE;
        start_store  = FALSE;
        store_accept = FALSE;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (head_entry.valid && head_ready && !halt) begin
                        if (head_entry.wr_mem) begin
                            start_store = TRUE;
                        end else begin
                            retire_alu = TRUE;
                        end
                    end
                end
                STORE_REQ: store_accept = mem_req_ready;
                default: ;
            endcase
        end
    end

    always_comb begin
        commit        = retire_alu | store_accept;
        rf_wr_en      = retire_alu && (head_entry.dest_reg != ZERO_REG);
        rf_wr_idx     = retire_alu ? head_entry.dest_reg : ZERO_REG;
        rf_wr_data    = retire_alu ? head_entry.value : XLEN'(0);
        mem_req_valid = (state == STORE_REQ);
        wait_inc      = (state == STORE_REQ) && !mem_req_ready &&
                        (wait_cnt != WAIT_W'(MAX_STORE_WAIT));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (start_store)  state <= STORE_REQ;
                STORE_REQ: if (store_accept) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Request payload is captured once so a moving ROB head cannot disturb it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_addr <= XLEN'(0);
            mem_req_data <= XLEN'(0);
        end else if (start_store) begin
            mem_req_addr <= head_entry.dest_addr;
            mem_req_data <= head_entry.value;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= WAIT_W'(0);
        end else if (start_store) begin
            wait_cnt <= WAIT_W'(0);
        end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Sticky flag raised on the edge where the wait counter reaches its limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            store_timeout <= FALSE;
        end else if (wait_inc && (wait_cnt == WAIT_W'(MAX_STORE_WAIT - 1))) begin
            store_timeout <= TRUE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            retired_count <= CNT_WIDTH'(0);
        end else if (commit) begin
            retired_count <= retired_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// Self-checking bench for commit_stage: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_commit_stage;
    import commit_stage_pkg::*;

    localparam int unsigned MAXW = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    ROB_ENTRY    head_entry;
    logic        head_ready = 1'b0;
    logic        halt = 1'b0;
    logic        mem_req_ready = 1'b0;
    logic        commit;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_idx;
    logic [31:0] rf_wr_data;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [31:0] retired_count;
    logic        store_timeout;

    int total = 0;
    int bad   = 0;

    commit_stage #(.MAX_STORE_WAIT(MAXW), .CNT_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .head_entry(head_entry),
        .head_ready(head_ready), .halt(halt), .mem_req_ready(mem_req_ready),
        .commit(commit), .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx),
        .rf_wr_data(rf_wr_data), .mem_req_valid(mem_req_valid),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .retired_count(retired_count), .store_timeout(store_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: a store is either outstanding or not; everything else is counting.
    logic        m_busy = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    int          m_wait = 0;
    logic        m_to   = 1'b0;
    logic [31:0] m_count = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_addr <= '0; m_data <= '0;
            m_wait <= 0; m_to <= 1'b0; m_count <= '0;
        end else if (m_busy) begin
            if (mem_req_ready) begin
                m_busy  <= 1'b0;
                m_count <= m_count + 32'd1;
            end else begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 >= int'(MAXW)) m_to <= 1'b1;
            end
        end else if (head_entry.valid && head_ready && !halt) begin
            if (head_entry.wr_mem) begin
                m_busy <= 1'b1;
                m_addr <= head_entry.dest_addr;
                m_data <= head_entry.value;
                m_wait <= 0;
            end else begin
                m_count <= m_count + 32'd1;
            end
        end
    end

    logic e_alu, e_commit;

    always @(negedge clock) begin
        e_alu    = reset && !m_busy && head_entry.valid && head_ready && !halt && !head_entry.wr_mem;
        e_commit = reset && (m_busy ? mem_req_ready : e_alu);
        chk("m_commit", 64'(commit), 64'(e_commit));
        chk("m_rf_wr_en", 64'(rf_wr_en), 64'(e_alu && head_entry.dest_reg != 5'd0));
        chk("m_rf_wr_idx", 64'(rf_wr_idx), e_alu ? 64'(head_entry.dest_reg) : 64'd0);
        chk("m_rf_wr_data", 64'(rf_wr_data), e_alu ? 64'(head_entry.value) : 64'd0);
        chk("m_req_valid", 64'(mem_req_valid), 64'(reset && m_busy));
        chk("m_req_addr", 64'(mem_req_addr), 64'(m_addr));
        chk("m_req_data", 64'(mem_req_data), 64'(m_data));
        chk("m_retired", 64'(retired_count), 64'(m_count));
        chk("m_timeout", 64'(store_timeout), 64'(m_to));
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic set_head(input logic v, input logic st, input logic [4:0] rd,
                            input logic [31:0] val, input logic [31:0] addr);
        head_entry.valid     = v;
        head_entry.wr_mem    = st;
        head_entry.dest_reg  = rd;
        head_entry.value     = val;
        head_entry.dest_addr = addr;
    endtask

    int rdy_pct;

    initial begin
        set_head(1'b1, 1'b0, 5'd3, 32'd5, 32'd0);
        head_ready = 1'b1;

        // Held in reset with a retirable head.
        repeat (2) begin
            @(negedge clock);
            chk("rst_commit", 64'(commit), 64'd0);
            chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
            chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
            chk("rst_retired", 64'(retired_count), 64'd0);
        end
        nxt();
        reset = 1'b1;

        @(negedge clock);
        chk("alu_commit", 64'(commit), 64'd1);
        chk("alu_wr_en", 64'(rf_wr_en), 64'd1);
        chk("alu_idx", 64'(rf_wr_idx), 64'd3);
        chk("alu_data", 64'(rf_wr_data), 64'd5);
        nxt();
        chk("alu_count", 64'(retired_count), 64'd1);

        set_head(1'b1, 1'b0, ZERO_REG, 32'd7, 32'd0);
        @(negedge clock);
        chk("x0_commit", 64'(commit), 64'd1);
        chk("x0_wr_en", 64'(rf_wr_en), 64'd0);
        nxt();

        // Store with three stalled cycles before acceptance.
        set_head(1'b1, 1'b1, 5'd9, 32'd10, 32'd11);
        mem_req_ready = 1'b0;
        @(negedge clock);
        chk("st_latch_commit", 64'(commit), 64'd0);
        nxt();
        set_head(1'b1, 1'b0, 5'd2, 32'hdead, 32'hbeef);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("st_wait_valid", 64'(mem_req_valid), 64'd1);
            chk("st_wait_addr", 64'(mem_req_addr), 64'd11);
            chk("st_wait_data", 64'(mem_req_data), 64'd10);
            chk("st_wait_commit", 64'(commit), 64'd0);
            nxt();
        end
        mem_req_ready = 1'b1;
        head_entry.valid = 1'b0;
        @(negedge clock);
        chk("st_acc_commit", 64'(commit), 64'd1);
        chk("st_acc_wr_en", 64'(rf_wr_en), 64'd0);
        chk("st_acc_addr", 64'(mem_req_addr), 64'd11);
        nxt();
        mem_req_ready = 1'b0;
        chk("st_done_valid", 64'(mem_req_valid), 64'd0);
        chk("st_done_timeout", 64'(store_timeout), 64'd0);
        chk("st_done_count", 64'(retired_count), 64'd3);

        // Over-long store wait, then reset mid-request.
        set_head(1'b1, 1'b1, 5'd1, 32'h99, 32'h40);
        nxt();
        head_entry.valid = 1'b0;
        repeat (14) nxt();
        chk("to_not_yet", 64'(store_timeout), 64'd0);
        repeat (2) nxt();
        chk("to_set", 64'(store_timeout), 64'd1);
        chk("to_still_req", 64'(mem_req_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("to_rst_valid", 64'(mem_req_valid), 64'd0);
        chk("to_rst_timeout", 64'(store_timeout), 64'd0);
        chk("to_rst_count", 64'(retired_count), 64'd0);
        nxt();
        reset = 1'b1;

        // Halt blocks a ready ALU head, then releases it.
        set_head(1'b1, 1'b0, 5'd4, 32'h123, 32'd0);
        halt = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("halt_commit", 64'(commit), 64'd0);
            nxt();
        end
        halt = 1'b0;
        @(negedge clock);
        chk("halt_rel_commit", 64'(commit), 64'd1);
        chk("halt_rel_idx", 64'(rf_wr_idx), 64'd4);
        nxt();
        chk("halt_rel_count", 64'(retired_count), 64'd1);

        // Halt raised while a store is outstanding does not block it.
        set_head(1'b1, 1'b1, 5'd6, 32'h55, 32'h80);
        nxt();
        head_entry.valid = 1'b0;
        halt = 1'b1;
        @(negedge clock);
        chk("hst_valid", 64'(mem_req_valid), 64'd1);
        nxt();
        mem_req_ready = 1'b1;
        @(negedge clock);
        chk("hst_commit", 64'(commit), 64'd1);
        nxt();
        halt = 1'b0;
        mem_req_ready = 1'b0;
        chk("hst_count", 64'(retired_count), 64'd2);

        // Randomized traffic; memory readiness drifts between phases.
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = int'($urandom_range(2, 95));
            reset         = ($urandom_range(0, 399) != 0);
            head_entry.valid     = ($urandom_range(0, 99) < 75);
            head_entry.wr_mem    = ($urandom_range(0, 99) < 30);
            head_entry.dest_reg  = 5'($urandom_range(0, 31));
            head_entry.value     = $urandom;
            head_entry.dest_addr = $urandom;
            head_ready    = ($urandom_range(0, 99) < 75);
            halt          = ($urandom_range(0, 99) < 10);
            mem_req_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            nxt();
        end

        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_stage.md
# commit_stage

In-order retirement stage that sits directly downstream of the reorder buffer (`rob`). Each cycle it inspects the ROB head (`head_entry`, `head_ready`) and retires at most one instruction. A non-store retires in the same cycle by writing the architectural register file. A store is first issued to data memory over a valid/ready handshake and retires only when memory accepts it. The `commit` output is the ROB's head-advance (dequeue) strobe.

## Interface
- `MAX_STORE_WAIT`, 15: cycles in `STORE_REQ` before `store_timeout` asserts.
- `CNT_WIDTH`, 32: width of `retired_count`.

- `clock` in 1: single clock domain.
- `reset` in 1: asynchronous, active-low; clears all state.
- `head_entry` in `ROB_ENTRY`: ROB head (`valid`, `wr_mem`, `dest_reg`, `value`, `dest_addr`).
- `head_ready` in 1: head result/address/value complete.
- `halt` in 1: debug stall; blocks new retirements only.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `commit` out 1: ROB dequeues its head at the next posedge.
- `rf_wr_en` out 1: register-file write enable.
- `rf_wr_idx` out 5: destination register.
- `rf_wr_data` out `XLEN`: write data.
- `mem_req_valid` out 1: store request valid.
- `mem_req_addr` out `XLEN`: store address.
- `mem_req_data` out `XLEN`: store data.
- `retired_count` out `CNT_WIDTH`: instructions retired since reset.
- `store_timeout` out 1: sticky; set by an over-long store wait.

## Operation
- FSM states: `IDLE` and `STORE_REQ`.
- `IDLE`, when `head_entry.valid && head_ready && !halt`:
  - Non-store (`!wr_mem`): combinational `commit=1` and `rf_wr_en=(dest_reg!=ZERO_REG)`, with `rf_wr_idx=dest_reg` and `rf_wr_data=value`. State stays `IDLE`.
  - Store: `commit=0`. At the posedge, latch `dest_addr` and `value` into the request registers, clear the wait counter, and go to `STORE_REQ`.
- `STORE_REQ`:
  - `mem_req_valid=1`; address and data come from the latched registers and stay stable until accepted.
  - When `mem_req_ready=1`: combinational `commit=1` (with `rf_wr_en=0`), then go to `IDLE`.
  - Otherwise the wait counter increments, saturating at `MAX_STORE_WAIT`. Reaching `MAX_STORE_WAIT` sets `store_timeout`, which holds until reset. The request is never dropped.
  - `halt` has no effect in this state.
- `retired_count` increments at every posedge where `commit=1`; it wraps modulo 2^`CNT_WIDTH`.
- `head_entry.valid=0` or `head_ready=0` in `IDLE`: no action.
- All outputs except the registered ones are combinational from state and inputs. No output may depend combinationally on `mem_req_ready` except `commit`.

## Timing
- Reset values: state `IDLE`, `commit=0`, `rf_wr_en=0`, `rf_wr_idx=0`, `rf_wr_data=0`, `mem_req_valid=0`, `mem_req_addr=0`, `mem_req_data=0`, `retired_count=0`, `store_timeout=0`.
- Non-store latency is 0 cycles: retires in the cycle `head_ready` is seen. Back-to-back non-stores retire at one per cycle.
- Store latency is at least 2 cycles: one cycle in `IDLE` to latch, then `STORE_REQ` until `mem_req_ready`. With `mem_req_ready` held high, a store retires every 2 cycles.
- A non-store following a store may retire in the cycle right after the store's acceptance.
- Reset asserted in `STORE_REQ`: the request is withdrawn immediately and state returns to `IDLE`. The ROB is reset alongside, so no retirement is lost.
- A head change while in `STORE_REQ` is ignored; the latched request governs.

## Structure
- `ROB_ENTRY`, `XLEN`, `ZERO_REG`, `TRUE`/`FALSE` and a new `COMMIT_STATE` enum live in the shared package.
- Single module with no sub-module. The store request register, wait counter and retire counter are local `always_ff` blocks with asynchronous clear.

## Test plan
- Reset: hold `reset=0` for 2 cycles with a ready non-store head → every output is 0 and `commit=0`.
- ALU retire: head {`valid=1`, `wr_mem=0`, `dest_reg=3`, `value=5`}, `head_ready=1` → same cycle `commit=1`, `rf_wr_en=1`, idx 3, data 5; `retired_count=1` after the posedge.
- x0 write: `dest_reg=ZERO_REG` → `commit=1`, `rf_wr_en=0`.
- Store handshake: store head {`dest_addr=11`, `value=10`}, `mem_req_ready=0` for 3 cycles then 1 → `mem_req_valid` holds addr 11 / data 10 for 4 cycles; `commit=1` only in the accept cycle; `store_timeout=0`.
- Timeout plus reset mid-store: `mem_req_ready=0` for 16 cycles → `store_timeout=1`, still requesting. Then pulse `reset` low → `mem_req_valid=0` and `store_timeout=0` immediately.
- Halt: `halt=1` with a ready non-store head → `commit=0` for 3 cycles; release → retires next cycle. `halt=1` asserted during `STORE_REQ` → store still retires on `mem_req_ready`.
